rx_ovs_funcmod: RTL and testbench

UART receive function module: 16x oversampled, majority-vote bit sampling, framing (and optional parity) error detection. It sits directly upstream of the byte FIFO in the UART loopback path. It is driven by the controller's `iCall`/`oDone` handshake, and its `oDone`/`oData` feed the FIFO write enable and write data. Frame format: 8N1, LSB first.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tick_gen.sv | 17 +
 rtl/rx_ovs_funcmod.sv | 101 ++++++++++
 tb/tb_rx_ovs_funcmod.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and oversampling constants.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  localparam int OVS_RATE = 16;
  localparam int DATA_BITS = 8;
  localparam logic [3:0] SMP_A = 4'd7;
  localparam logic [3:0] SMP_B = 4'd8;
  localparam logic [3:0] SMP_C = 4'd9;
  localparam logic [3:0] OVS_LAST = 4'(OVS_RATE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: oversample tick divider, one-cycle oTick every TICK_DIV clocks.
module uart_tick_gen #(
  parameter int TICK_DIV = 27
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic iClear,
  output logic oTick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] r_cnt;
  assign oTick = r_cnt == W'(TICK_DIV - 1);
  always_ff @(posedge CLOCK) begin
    if (RESET || iClear) r_cnt <= '0;
    else r_cnt <= oTick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/rx_ovs_funcmod.sv
// rx_ovs_funcmod: 16x oversampled UART receiver with 3-sample majority vote; define RX_PARITY_EN for 8E1 (default 8N1).
module rx_ovs_funcmod
  import uart_pkg::*;
#(
  parameter int TICK_DIV = 27
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       RXD,
  input  logic       iCall,
  output logic       oDone,
  output logic [7:0] oData,
  output logic       oErr
);
  logic [1:0] r_sync;
  state_t     r_state;
  logic [3:0] r_ovs;
  logic [2:0] r_bit;
  logic [7:0] r_shreg;
  logic       r_sa, r_sb;
  logic       w_rxs, w_tick, w_maj, w_dec, w_bnd, w_perr;

  uart_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .iClear(r_state == IDLE),
    .oTick (w_tick)
  );

  assign w_rxs = r_sync[1];
  assign w_maj = maj3(r_sa, r_sb, w_rxs);
  assign w_dec = w_tick && r_ovs == SMP_C;
  assign w_bnd = w_tick && r_ovs == OVS_LAST;

`ifdef RX_PARITY_EN
  logic r_par;
  localparam state_t AFTER_DATA = PARITY;
  assign w_perr = ^{r_shreg, r_par};
`else
  localparam state_t AFTER_DATA = STOP;
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_sync  <= 2'b11;
      r_state <= IDLE;
      r_ovs   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_sa    <= 1'b1;
      r_sb    <= 1'b1;
      oDone   <= 1'b0;
      oData   <= '0;
      oErr    <= 1'b0;
`ifdef RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], RXD};
      oDone  <= 1'b0;
      if (w_tick) r_ovs <= r_ovs + 1'b1;
      if (w_tick && r_ovs == SMP_A) r_sa <= w_rxs;
      if (w_tick && r_ovs == SMP_B) r_sb <= w_rxs;
      // Dropping iCall mid-frame abandons it silently; outputs keep the last frame.
      if (r_state inside {START, DATA, PARITY, STOP} && !iCall) r_state <= IDLE;
      else begin
        case (r_state)
          IDLE: if (iCall && !w_rxs) begin
            r_state <= START;
            r_ovs   <= '0;
            r_bit   <= '0;
          end
          START: r_state <= (w_dec && w_maj) ? IDLE : w_bnd ? DATA : START;
          DATA: begin
            if (w_dec) r_shreg <= {w_maj, r_shreg[7:1]};
            if (w_bnd) begin
              r_bit <= r_bit + 1'b1;
              if (r_bit == BIT_LAST) r_state <= AFTER_DATA;
            end
          end
`ifdef RX_PARITY_EN
          PARITY: begin
            if (w_dec) r_par <= w_maj;
            if (w_bnd) r_state <= STOP;
          end
`endif
          // Finish at mid stop bit so a back-to-back start edge is never missed.
          STOP: if (w_dec) begin
            r_state <= DONE;
            oDone   <= 1'b1;
            oData   <= r_shreg;
            oErr    <= ~w_maj | w_perr;
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_ovs_funcmod.sv
// tb_rx_ovs_funcmod: directed plus random frames checked against a frame-level receive model.
module tb_rx_ovs_funcmod;
  localparam int TD = 4;
`ifdef RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // line-to-oDone: 2 synchroniser cycles, stop decision tick, then the DONE register
  localparam int LAT = 3 + (16 * (NB - 1) + 10) * TD;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       e;
  } rec_t;

  logic       clk = 1'b0;
  logic       RESET, RXD, iCall;
  logic       oDone, oErr;
  logic [7:0] oData;
  int         cyc = 0, checks = 0, errors = 0;
  logic       hs = 1'b0;
  logic [7:0] last_d = 8'h00;
  logic       last_e = 1'b0;
  rec_t       exp_q[$], got_q[$];

  rx_ovs_funcmod #(.TICK_DIV(TD)) dut (
    .CLOCK(clk),
    .RESET(RESET),
    .RXD  (RXD),
    .iCall(iCall),
    .oDone(oDone),
    .oData(oData),
    .oErr (oErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v);
    RXD = v;
    @(posedge clk);
    #1;
    cyc++;
    if (oDone) got_q.push_back('{cyc, oData, oErr});
    if (hs) iCall = ~oDone;
  endtask

  // act: 0 normal, 1 drop iCall in data bit 4, 2 reset pulse (and iCall drop) in data bit 4
  task automatic send(input logic [7:0] d, input logic stop, input logic pbad,
                      input logic gl, input int act, input int gap);
    logic [10:0] b;
    logic        e;
`ifdef RX_PARITY_EN
    b = {stop, ^d ^ pbad, d, 1'b0};
    e = ~stop | pbad;
`else
    b = {1'b0, stop, d, 1'b0};
    e = ~stop;
`endif
    if (act == 0) exp_q.push_back('{cyc + LAT, d, e});
    for (int k = 0; k < NB; k++) begin
      for (int o = 0; o < 64; o++) begin
        if (act != 0 && k == 5 && o == 32) begin
          iCall = 1'b0;
          if (act == 2) RESET = 1'b1;
        end
        if (act == 2 && k == 5 && o == 33) begin
          RESET = 1'b0;
          chk("rst_done", int'(oDone), 0);
          chk("rst_data", int'(oData), 0);
          chk("rst_err", int'(oErr), 0);
          last_d = 8'h00;
          last_e = 1'b0;
        end
        drive(b[k] ^ (gl && k >= 1 && k <= 8 && o >= 34 && o <= 37));
      end
    end
    repeat (gap) drive(1'b1);
    if (act != 0) iCall = 1'b1;
  endtask

  task automatic compare(input string tag);
    rec_t g, x;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_cycle"}, g.cyc, x.cyc);
      chk({tag, "_data"}, int'(g.d), int'(x.d));
      chk({tag, "_err"}, int'(g.e), int'(x.e));
      last_d = x.d;
      last_e = x.e;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       st;
    RESET = 1'b1;
    RXD   = 1'b1;
    iCall = 1'b0;
    repeat (3) drive(1'b1);
    RESET = 1'b0;
    drive(1'b1);
    chk("reset_done", int'(oDone), 0);
    chk("reset_data", int'(oData), 0);
    chk("reset_err", int'(oErr), 0);
    iCall = 1'b1;
    repeat (5) drive(1'b1);

    send(8'h55, 1'b1, 1'b0, 1'b0, 0, 20);
    compare("valid55");

    repeat (20) drive(1'b0);
    repeat (64) drive(1'b1);
    send(8'hC3, 1'b1, 1'b0, 1'b0, 0, 20);
    compare("glitch_c3");

    send(8'hA3, 1'b0, 1'b0, 1'b0, 0, 70);
    send(8'h01, 1'b1, 1'b0, 1'b0, 0, 20);
    compare("framing");

    send(8'h0F, 1'b1, 1'b0, 1'b1, 0, 20);
    compare("majority");

    send(8'h3C, 1'b1, 1'b0, 1'b0, 1, 20);
    compare("abort");
    chk("abort_hold_data", int'(oData), int'(last_d));
    chk("abort_hold_err", int'(oErr), int'(last_e));
    send(8'h5A, 1'b1, 1'b0, 1'b0, 2, 20);
    compare("reset_mid");
    chk("reset_mid_data", int'(oData), 0);
    send(8'h81, 1'b1, 1'b0, 1'b0, 0, 20);
    compare("after_reset");

    hs = 1'b1;
    send(8'h11, 1'b1, 1'b0, 1'b0, 0, 0);
    send(8'h22, 1'b1, 1'b0, 1'b0, 0, 0);
    send(8'h33, 1'b1, 1'b0, 1'b0, 0, 20);
    hs = 1'b0;
    iCall = 1'b1;
    compare("handshake");
`ifdef RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0, 1'b0, 0, 20);
    send(8'h07, 1'b1, 1'b1, 1'b0, 0, 20);
    compare("parity");
`endif

    repeat (25) begin
      d  = 8'($urandom);
      st = $urandom_range(0, 3) != 0;
      send(d, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
           st ? $urandom_range(0, 15) : 70);
      compare("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
